// File: rtl/proc_io_ctrl.sv
// Processor I/O bridge: one-entry input holding registers per channel, ODEPTH-deep output FIFOs.
// Reads/writes complete at the next edge; proc_stall holds the core while a read channel is empty or a write FIFO is full.

module proc_io_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push_vld,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_dat,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty    = (r_wptr == r_rptr);
  assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head_dat = r_mem[r_rptr[AW-1:0]];
  assign w_do_push  = i_push_vld && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_push_dat;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
endmodule

module proc_io_ctrl #(
  parameter int NCH    = 3,
  parameter int DW     = 32,
  parameter int ODEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH-1:0]    proc_req,
  output logic [DW-1:0]     proc_in,
  input  logic [DW-1:0]     proc_out,
  input  logic [NCH-1:0]    proc_oen,
  output logic              proc_stall,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic              err_sel
);
  logic [DW-1:0]  r_ibuf [NCH];
  logic [NCH-1:0] r_ifull;
  logic           r_err;

  logic [3:0]     w_req_cnt;
  logic [3:0]     w_oen_cnt;
  logic [NCH-1:0] w_req_sel;
  logic [NCH-1:0] w_oen_sel;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_consume;
  logic [NCH-1:0] w_push;
  logic           w_rd_block;
  logic           w_wr_block;

  always_comb begin
    w_req_cnt = '0;
    w_oen_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_req_cnt = w_req_cnt + 4'(proc_req[i]);
      w_oen_cnt = w_oen_cnt + 4'(proc_oen[i]);
    end
  end

  // Zero or multi-hot strobes select nothing, so they neither stall nor transfer.
  assign w_req_sel  = (w_req_cnt == 4'd1) ? proc_req : '0;
  assign w_oen_sel  = (w_oen_cnt == 4'd1) ? proc_oen : '0;
  assign w_rd_block = |(w_req_sel & ~r_ifull);
  assign w_wr_block = |(w_oen_sel & w_full);
  assign proc_stall = w_rd_block || w_wr_block;
  assign w_consume  = proc_stall ? '0 : (w_req_sel & r_ifull);
  assign w_push     = proc_stall ? '0 : w_oen_sel;

  always_comb begin
    proc_in = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_req_sel[i] && r_ifull[i]) proc_in = r_ibuf[i];
    end
  end

  assign in_ready  = ~r_ifull;
  assign out_valid = ~w_empty;
  assign err_sel   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifull <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NCH; i++) r_ibuf[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_valid[i] && !r_ifull[i]) begin
          r_ibuf[i]  <= in_data[i*DW +: DW];
          r_ifull[i] <= 1'b1;
        end else if (w_consume[i]) begin
          r_ifull[i] <= 1'b0;
        end
      end
      if ((w_req_cnt > 4'd1) || (w_oen_cnt > 4'd1)) r_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ofifo
    proc_io_fifo #(.DW(DW), .DEPTH(ODEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push_vld (w_push[g]),
      .i_push_dat (proc_out),
      .i_pop      (out_ready[g]),
      .o_head_dat (out_data[g*DW +: DW]),
      .o_full     (w_full[g]),
      .o_empty    (w_empty[g])
    );
  end
endmodule

// File: tb/tb_proc_io_ctrl.sv
// Directed scenarios plus a randomized phase checked against a queue-level model of the I/O bridge.
module tb_proc_io_ctrl;
  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int OD  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] in_data = '0;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH-1:0]    in_ready;
  logic [NCH-1:0]    proc_req = '0;
  logic [DW-1:0]     proc_in;
  logic [DW-1:0]     proc_out = '0;
  logic [NCH-1:0]    proc_oen = '0;
  logic              proc_stall;
  logic [NCH*DW-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready = '0;
  logic              err_sel;

  int total = 0;
  int bad   = 0;

  // Reference model state: holding registers and FIFO contents as shift arrays.
  logic [DW-1:0] m_ibuf [NCH];
  logic          m_ifull [NCH];
  logic [DW-1:0] m_q [NCH][OD];
  int            m_cnt [NCH];
  int            r_ch, w_ch;
  logic          e_stall;
  logic [DW-1:0] e_in;
  logic          pre_full [NCH];
  logic [2:0]    hot_tab [4];

  proc_io_ctrl #(.NCH(NCH), .DW(DW), .ODEPTH(OD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .proc_req(proc_req), .proc_in(proc_in), .proc_out(proc_out), .proc_oen(proc_oen),
    .proc_stall(proc_stall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int hot(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [DW-1:0] och(input int c);
    return out_data[c*DW +: DW];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_ifull[c] = 1'b0;
      m_ibuf[c]  = '0;
      m_cnt[c]   = 0;
    end
  endtask

  initial begin
    hot_tab[0] = 3'b000; hot_tab[1] = 3'b001; hot_tab[2] = 3'b010; hot_tab[3] = 3'b100;

    // Reset state, with a capture request already pending on ch1.
    in_valid = 3'b010;
    in_data[1*DW +: DW] = 32'hFFFF_FFF6;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'h7);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data0", och(0), 32'h0);
    chk("rst_proc_in", proc_in, 32'h0);
    chk("rst_stall", 32'(proc_stall), 32'h0);
    chk("rst_err", 32'(err_sel), 32'h0);
    #1 rst = 1'b0;

    // Read scenario: first edge after reset captures ch1, then the core reads -10.
    step();
    in_valid = '0;
    chk("s1_in_ready_fall", 32'(in_ready), 32'h5);
    proc_req = 3'b010;
    #1;
    chk("s1_proc_in", proc_in, 32'hFFFF_FFF6);
    chk("s1_stall", 32'(proc_stall), 32'h0);
    step();
    proc_req = '0;
    #1;
    chk("s1_in_ready_back", 32'(in_ready), 32'h7);

    // Read stall: ch2 empty, then captured.
    proc_req = 3'b100;
    #1;
    chk("s2_stall", 32'(proc_stall), 32'h1);
    chk("s2_proc_in0", proc_in, 32'h0);
    in_valid = 3'b100;
    in_data[2*DW +: DW] = 32'd7;
    step();
    in_valid = '0;
    #1;
    chk("s2_stall_drop", 32'(proc_stall), 32'h0);
    chk("s2_proc_in7", proc_in, 32'd7);
    step();
    proc_req = '0;
    #1;
    chk("s2_in_ready2", 32'(in_ready[2]), 32'h1);

    // Write overflow on ch0.
    out_ready = '0;
    for (int k = 1; k <= 4; k++) begin
      proc_oen = 3'b001;
      proc_out = 32'(k);
      #1;
      chk("s3_no_stall", 32'(proc_stall), 32'h0);
      step();
      if (k == 1) begin
        chk("s3_valid_rise", 32'(out_valid[0]), 32'h1);
        chk("s3_head1", och(0), 32'd1);
      end
    end
    proc_out = 32'd5;
    #1;
    chk("s3_fifth_stall", 32'(proc_stall), 32'h1);
    step();
    out_ready = 3'b001;
    #1;
    chk("s3_stall_with_pop", 32'(proc_stall), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("s3_pop_order", och(0), 32'(k));
      if (k == 2) chk("s3_stall_clear", 32'(proc_stall), 32'h0);
      step();
      if (k == 2) proc_oen = '0;
    end
    chk("s3_drained", 32'(out_valid[0]), 32'h0);
    out_ready = '0;

    // Concurrent read and write both blocked by the write side.
    in_valid = 3'b001;
    in_data[0*DW +: DW] = 32'hAA;
    step();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      proc_oen = 3'b010;
      proc_out = 32'(11 + k);
      step();
    end
    proc_req = 3'b001;
    proc_oen = 3'b010;
    proc_out = 32'd99;
    #1;
    chk("s4_stall", 32'(proc_stall), 32'h1);
    step();
    proc_req = '0;
    proc_oen = '0;
    #1;
    chk("s4_ch0_kept", 32'(in_ready[0]), 32'h0);
    out_ready = 3'b010;
    for (int k = 0; k < 4; k++) begin
      chk("s4_drain", och(1), 32'(11 + k));
      step();
    end
    chk("s4_no_push", 32'(out_valid[1]), 32'h0);
    out_ready = '0;

    // Randomized phase from a clean reset.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_clear();
    for (int n = 0; n < 400; n++) begin
      in_valid  = 3'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      proc_req  = hot_tab[$urandom_range(0, 3)];
      proc_oen  = hot_tab[$urandom_range(0, 3)];
      proc_out  = $urandom;
      out_ready = 3'($urandom);
      #1;
      r_ch = hot(proc_req);
      w_ch = hot(proc_oen);
      e_stall = ((r_ch >= 0) && !m_ifull[r_ch]) || ((w_ch >= 0) && (m_cnt[w_ch] == OD));
      e_in = ((r_ch >= 0) && m_ifull[r_ch]) ? m_ibuf[r_ch] : '0;
      chk("rnd_stall", 32'(proc_stall), 32'(e_stall));
      chk("rnd_proc_in", proc_in, e_in);
      for (int c = 0; c < NCH; c++) begin
        chk("rnd_in_ready", 32'(in_ready[c]), 32'(!m_ifull[c]));
        chk("rnd_out_valid", 32'(out_valid[c]), 32'(m_cnt[c] > 0));
        if (m_cnt[c] > 0) chk("rnd_out_data", och(c), m_q[c][0]);
      end
      for (int c = 0; c < NCH; c++) pre_full[c] = (m_cnt[c] == OD);
      for (int c = 0; c < NCH; c++) begin
        if (out_ready[c] && m_cnt[c] > 0) begin
          for (int j = 0; j < OD - 1; j++) m_q[c][j] = m_q[c][j+1];
          m_cnt[c]--;
        end
      end
      if (!e_stall && w_ch >= 0 && !pre_full[w_ch]) begin
        m_q[w_ch][m_cnt[w_ch]] = proc_out;
        m_cnt[w_ch]++;
      end
      for (int c = 0; c < NCH; c++) begin
        if (in_valid[c] && !m_ifull[c]) begin
          m_ibuf[c]  = in_data[c*DW +: DW];
          m_ifull[c] = 1'b1;
        end else if (!e_stall && r_ch == c) begin
          m_ifull[c] = 1'b0;
        end
      end
      step();
    end

    // Error and asynchronous reset.
    in_valid = '0; proc_req = '0; proc_oen = '0; out_ready = '0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    in_valid = 3'b100;
    in_data[2*DW +: DW] = 32'd3;
    proc_oen = 3'b011;
    proc_out = 32'd42;
    #1;
    chk("s5_multihot_nostall", 32'(proc_stall), 32'h0);
    step();
    in_valid = '0;
    proc_oen = '0;
    #1;
    chk("s5_err_set", 32'(err_sel), 32'h1);
    chk("s5_no_push", 32'(out_valid), 32'h0);
    proc_oen = 3'b001;
    proc_out = 32'd8;
    step();
    proc_oen = '0;
    #1;
    chk("s5_err_sticky", 32'(err_sel), 32'h1);
    chk("s5_pre_rst_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("s5_rst_err", 32'(err_sel), 32'h0);
    chk("s5_rst_valid", 32'(out_valid), 32'h0);
    chk("s5_rst_ready", 32'(in_ready), 32'h7);
    chk("s5_rst_head", och(0), 32'h0);
    #1 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
